// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-requester memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam logic [3:0] RW_READ        = 4'b0000;
  localparam int         DEF_ADDRWIDTH  = 16;
  localparam int         DEF_DATAWIDTH  = 32;
  localparam int         DEF_WAITSTATES = 3;

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  function automatic req_id_t pick_winner(input logic i_req, input logic d_req,
                                          input req_id_t last);
    req_id_t w;
    if (i_req && d_req) w = (last == REQ_I) ? REQ_D : REQ_I;
    else if (i_req)     w = REQ_I;
    else                w = REQ_D;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side request/response and memory-side signals of the arbiter.
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
);

  logic                 I_Strobe;
  logic [ADDRWIDTH-1:0] I_Address;
  logic [3:0]           I_RW;
  logic [DATAWIDTH-1:0] I_WData;
  logic [DATAWIDTH-1:0] I_RData;
  logic                 I_Ready;

  logic                 D_Strobe;
  logic [ADDRWIDTH-1:0] D_Address;
  logic [3:0]           D_RW;
  logic [DATAWIDTH-1:0] D_WData;
  logic [DATAWIDTH-1:0] D_RData;
  logic                 D_Ready;

  logic                 MemStrobe;
  logic [ADDRWIDTH-1:0] MemAddress;
  logic [3:0]           MemRW;
  logic [DATAWIDTH-1:0] MemWData;
  logic [DATAWIDTH-1:0] MemRData;

  modport slave (
    input  I_Strobe, I_Address, I_RW, I_WData,
    output I_RData, I_Ready,
    input  D_Strobe, D_Address, D_RW, D_WData,
    output D_RData, D_Ready,
    output MemStrobe, MemAddress, MemRW, MemWData,
    input  MemRData
  );

  modport master (
    output I_Strobe, I_Address, I_RW, I_WData,
    input  I_RData, I_Ready,
    output D_Strobe, D_Address, D_RW, D_WData,
    input  D_RData, D_Ready,
    input  MemStrobe, MemAddress, MemRW, MemWData,
    output MemRData
  );

endinterface

// File: rtl/bus_wait_ctr.sv
// 4-bit memory wait-state down-counter; load has priority, decrement stops at zero.
module bus_wait_ctr (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting one I- or D-cache access at a time to a single memory port.
// Accepts in IDLE, holds BUSY for WAITSTATES+1 cycles, pulses the winner's Ready in DONE.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int WAITSTATES = DEF_WAITSTATES,
  parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int DATAWIDTH  = DEF_DATAWIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_bus_arbiter_if.slave  bus
);

  state_t               state_q,      state_d;
  req_id_t              last_q,       last_d;
  req_id_t              win_q,        win_d;
  logic                 mem_strobe_q, mem_strobe_d;
  logic [ADDRWIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [3:0]           mem_rw_q,     mem_rw_d;
  logic [DATAWIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic [DATAWIDTH-1:0] i_rdata_q,    i_rdata_d;
  logic [DATAWIDTH-1:0] d_rdata_q,    d_rdata_d;
  logic                 i_ready_q,    i_ready_d;
  logic                 d_ready_q,    d_ready_d;

  logic ctr_load;
  logic ctr_dec;
  logic ctr_zero;

  bus_wait_ctr u_wait_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (ctr_load),
    .load_val (4'(WAITSTATES)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      last_q       <= REQ_D;
      win_q        <= REQ_I;
      mem_strobe_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_rw_q     <= RW_READ;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      mem_strobe_q <= mem_strobe_d;
      mem_addr_q   <= mem_addr_d;
      mem_rw_q     <= mem_rw_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    mem_strobe_d = mem_strobe_q;
    mem_addr_d   = mem_addr_q;
    mem_rw_d     = mem_rw_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    ctr_load     = 1'b0;
    ctr_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.I_Strobe || bus.D_Strobe) begin
          win_d        = pick_winner(bus.I_Strobe, bus.D_Strobe, last_q);
          mem_addr_d   = (win_d == REQ_I) ? bus.I_Address : bus.D_Address;
          mem_rw_d     = (win_d == REQ_I) ? bus.I_RW      : bus.D_RW;
          mem_wdata_d  = (win_d == REQ_I) ? bus.I_WData   : bus.D_WData;
          mem_strobe_d = 1'b1;
          ctr_load     = 1'b1;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        if (!ctr_zero) begin
          ctr_dec = 1'b1;
        end else begin
          // MemRW still holds the latched enables here, so it tells read from write.
          if (mem_rw_q == RW_READ) begin
            if (win_q == REQ_I) i_rdata_d = bus.MemRData;
            else                d_rdata_d = bus.MemRData;
          end
          if (win_q == REQ_I) i_ready_d = 1'b1;
          else                d_ready_d = 1'b1;
          last_d       = win_q;
          mem_strobe_d = 1'b0;
          mem_rw_d     = RW_READ;
          state_d      = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.MemStrobe  = mem_strobe_q;
  assign bus.MemAddress = mem_addr_q;
  assign bus.MemRW      = mem_rw_q;
  assign bus.MemWData   = mem_wdata_q;
  assign bus.I_RData    = i_rdata_q;
  assign bus.I_Ready    = i_ready_q;
  assign bus.D_RData    = d_rdata_q;
  assign bus.D_Ready    = d_ready_q;

endmodule
